// File: rtl/spk_bram_ctrl.sv
// Spike BRAM controller: round-robin sharing of the single read port, write
// pass-through from the spike producer, and a full-buffer zero-fill sequencer.
module spk_bram_ctrl #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned RAM_DEPTH      = 32,
   parameter int unsigned RAM_WIDTH      = 32,
   parameter int unsigned RAM_ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NUM_REQ-1:0]                req_valid_i,
   input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]                req_ready_o,
   output logic [NUM_REQ-1:0]                rsp_valid_o,
   output logic [RAM_WIDTH-1:0]              rsp_data_o,
   input  logic                              wr_valid_i,
   input  logic [RAM_ADDR_WIDTH-1:0]         wr_addr_i,
   input  logic [RAM_WIDTH-1:0]              wr_data_i,
   output logic                              wr_ready_o,
   input  logic                              clr_start_i,
   output logic                              clr_busy_o,
   output logic                              clr_done_o,
   output logic                              bram_wren_o,
   output logic [RAM_ADDR_WIDTH-1:0]         bram_wraddr_o,
   output logic [RAM_WIDTH-1:0]              bram_wrdat_o,
   output logic                              bram_ren_o,
   output logic [RAM_ADDR_WIDTH-1:0]         bram_raddr_o,
   input  logic [RAM_WIDTH-1:0]              bram_rdat_i
);
   localparam int unsigned AW = RAM_ADDR_WIDTH;
   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
   localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [AW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0] rv_q, rv_d;
   logic               done_q, done_d;
   logic [NUM_REQ-1:0] elig;
   logic [PW-1:0]      win;
   logic               found;

   // A read hitting the address being written this cycle would see stale data.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid_i[i] &
                   ~(wr_valid_i & (req_addr_i[i*AW +: AW] == wr_addr_i));
      end
   end

   // Round-robin search starting at ptr_q.
   always_comb begin
      logic [PW-1:0] idx;
      found = 1'b0;
      win   = ptr_q;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = PW'((32'(ptr_q) + k) % NUM_REQ);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      rv_d          = '0;
      done_d        = 1'b0;
      req_ready_o   = '0;
      wr_ready_o    = 1'b0;
      bram_wren_o   = 1'b0;
      bram_wraddr_o = wr_addr_i;
      bram_wrdat_o  = wr_data_i;
      bram_ren_o    = 1'b0;
      bram_raddr_o  = '0;
      clr_busy_o    = 1'b0;

      unique case (state_q)
         IDLE: begin
            wr_ready_o  = 1'b1;
            bram_wren_o = wr_valid_i;
            if (found) begin
               req_ready_o[win] = 1'b1;
               rv_d[win]        = 1'b1;
               bram_ren_o       = 1'b1;
               bram_raddr_o     = req_addr_i[32'(win)*AW +: AW];
               ptr_d            = (win == LAST_REQ) ? '0 : win + 1'b1;
            end
            if (clr_start_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            clr_busy_o    = 1'b1;
            bram_wren_o   = 1'b1;
            bram_wraddr_o = cnt_q;
            bram_wrdat_o  = '0;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake and BRAM strobes drop as soon as reset asserts.
      if (!rst_ni) begin
         req_ready_o = '0;
         wr_ready_o  = 1'b0;
         bram_wren_o = 1'b0;
         bram_ren_o  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         rv_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         rv_q    <= rv_d;
         done_q  <= done_d;
      end
   end

   assign rsp_valid_o = rv_q;
   assign rsp_data_o  = bram_rdat_i;
   assign clr_done_o  = done_q;

endmodule

// File: tb/tb_spk_bram_ctrl.sv
// Bench for spk_bram_ctrl: BRAM model, cycle-level reference model and
// directed/randomized scenarios.
module tb_spk_bram_ctrl;
   localparam int unsigned N  = 4;
   localparam int unsigned D  = 32;
   localparam int unsigned W  = 32;
   localparam int unsigned AW = 5;

   logic           clk, rst_n;
   logic [N-1:0]   req_valid, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [W-1:0]   rsp_data, wr_data, bram_wrdat, bram_rdat;
   logic           wr_valid, wr_ready, clr_start, clr_busy, clr_done;
   logic [AW-1:0]  wr_addr, bram_wraddr, bram_raddr;
   logic           bram_wren, bram_ren;
   logic [W-1:0]   bram_mem [D];

   int errors, checks;

   // Reference model state
   logic [W-1:0] m_mem [D];
   logic [W-1:0] snap  [D];
   int           m_ptr, m_cnt;
   bit           m_clr, m_done;
   logic [N-1:0] m_prev;
   logic [W-1:0] m_pdata;
   logic [N-1:0] e_grant;
   bit           e_wren;
   logic [AW-1:0] e_waddr, e_raddr;
   logic [W-1:0] e_wdata;

   spk_bram_ctrl #(.NUM_REQ(N), .RAM_DEPTH(D), .RAM_WIDTH(W), .RAM_ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
      .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done),
      .bram_wren_o(bram_wren), .bram_wraddr_o(bram_wraddr), .bram_wrdat_o(bram_wrdat),
      .bram_ren_o(bram_ren), .bram_raddr_o(bram_raddr), .bram_rdat_i(bram_rdat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first BRAM with one-cycle registered read
   always @(posedge clk) begin
      if (bram_ren) bram_rdat <= bram_mem[bram_raddr];
      if (bram_wren) bram_mem[bram_wraddr] <= bram_wrdat;
   end

   function automatic void model_reset();
      m_ptr = 0; m_cnt = 0; m_clr = 0; m_done = 0; m_prev = '0; m_pdata = '0;
   endfunction

   // Expected combinational outputs for the inputs currently applied.
   function automatic void model_eval();
      e_grant = '0;
      e_raddr = '0;
      if (!m_clr) begin
         for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (e_grant == 0 && req_valid[i] && !(wr_valid && req_addr[i*AW +: AW] == wr_addr)) begin
               e_grant[i] = 1'b1;
               e_raddr    = req_addr[i*AW +: AW];
            end
         end
         e_wren = wr_valid; e_waddr = wr_addr; e_wdata = wr_data;
      end else begin
         e_wren = 1; e_waddr = AW'(m_cnt); e_wdata = '0;
      end
   endfunction

   // Advance the model across the coming rising edge.
   function automatic void model_commit();
      m_prev = e_grant;
      for (int i = 0; i < N; i++) begin
         if (e_grant[i]) begin
            m_pdata = m_mem[e_raddr];
            m_ptr   = (i + 1) % N;
         end
      end
      if (e_wren) m_mem[e_waddr] = e_wdata;
      m_done = 0;
      if (m_clr) begin
         if (m_cnt == D - 1) begin m_clr = 0; m_done = 1; m_cnt = 0; end
         else m_cnt++;
      end else if (clr_start) begin
         m_clr = 1; m_cnt = 0;
      end
   endfunction

   task automatic drive_idle();
      req_valid = '0; req_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0; clr_start = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      req_valid = '1; wr_valid = 1;
      #1;
      checks++;
      if ({req_ready, rsp_valid, wr_ready, bram_ren, bram_wren, clr_busy, clr_done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rr=%b rv=%b wr=%b ren=%b wen=%b busy=%b done=%b, want all 0",
                  req_ready, rsp_valid, wr_ready, bram_ren, bram_wren, clr_busy, clr_done);
      end
      drive_idle();
      @(negedge clk);
      rst_n = 1;
      #1;
      model_reset(); model_eval();
      checks++;
      if (wr_ready !== 1'b1 || req_ready !== '0 || rsp_valid !== '0 || clr_busy !== 0 || clr_done !== 0) begin
         errors++;
         $display("FAIL post_reset_idle: got wr_ready=%b rr=%b rv=%b busy=%b done=%b", wr_ready, req_ready,
                  rsp_valid, clr_busy, clr_done);
      end
      model_commit();
   endtask

   // Fill the buffer through the write port with random data.
   task automatic test_write_passthru();
      for (int a = 0; a < D; a++) begin
         @(negedge clk);
         drive_idle();
         wr_valid = 1; wr_addr = AW'(a); wr_data = $urandom;
         #1; model_eval();
         checks++;
         if (bram_wren !== 1'b1 || bram_wraddr !== AW'(a) || bram_wrdat !== wr_data || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_passthru a=%0d: got wren=%b addr=%0d data=%h rdy=%b, want 1/%0d/%h/1",
                     a, bram_wren, bram_wraddr, bram_wrdat, wr_ready, a, wr_data);
         end
         model_commit();
      end
   endtask

   task automatic test_rr_all();
      logic [N-1:0] exp_g;
      for (int n = 0; n < 9; n++) begin
         @(negedge clk);
         drive_idle();
         req_valid = '1;
         for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
         #1; model_eval();
         exp_g = N'(1) << (n % N);
         checks++;
         if (req_ready !== exp_g || bram_ren !== 1'b1 || bram_raddr !== AW'(n % N)) begin
            errors++;
            $display("FAIL rr_grant n=%0d: got %b raddr=%0d, want %b raddr=%0d", n, req_ready, bram_raddr,
                     exp_g, n % N);
         end
         if (n > 0) begin
            checks++;
            if (rsp_valid !== m_prev || rsp_data !== m_pdata) begin
               errors++;
               $display("FAIL rr_rsp n=%0d: got %b/%h, want %b/%h", n, rsp_valid, rsp_data, m_prev, m_pdata);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_ptr_wrap();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         drive_idle();
         req_valid[2] = 1; req_addr[2*AW +: AW] = 5'd5;
         if (n == 2) begin req_valid[3] = 1; req_addr[3*AW +: AW] = 5'd9; end
         #1; model_eval();
         checks++;
         if (req_ready !== ((n == 2) ? 4'b1000 : 4'b0100)) begin
            errors++;
            $display("FAIL ptr_grant n=%0d: got %b, want %b", n, req_ready, (n == 2) ? 4'b1000 : 4'b0100);
         end
         if (n == 2) begin
            checks++;
            if (rsp_valid !== 4'b0100 || rsp_data !== m_mem[5]) begin
               errors++;
               $display("FAIL ptr_rsp: got %b/%h, want 0100/%h", rsp_valid, rsp_data, m_mem[5]);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_collision();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         drive_idle();
         if (n == 0) begin
            wr_valid = 1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
            req_valid = 4'b0011; req_addr[0 +: AW] = 5'd7; req_addr[AW +: AW] = 5'd8;
         end else if (n == 1) begin
            req_valid = 4'b0001; req_addr[0 +: AW] = 5'd7;
         end
         #1; model_eval();
         checks++;
         if (req_ready !== ((n == 0) ? 4'b0010 : (n == 1) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("FAIL collision_grant n=%0d: got %b", n, req_ready);
         end
         if (n == 2) begin
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== 32'hA5A5A5A5) begin
               errors++;
               $display("FAIL collision_rsp: got %b/%h, want 0001/a5a5a5a5", rsp_valid, rsp_data);
            end
         end
         model_commit();
      end
   endtask

   // Read every entry through requester 0; entries below lim must be zero.
   task automatic read_all(input int lim);
      logic [W-1:0] exp_d;
      for (int a = 0; a <= D; a++) begin
         @(negedge clk);
         drive_idle();
         if (a < D) begin req_valid = 4'b0001; req_addr[0 +: AW] = AW'(a); end
         #1; model_eval();
         if (a < D) begin
            checks++;
            if (req_ready !== 4'b0001) begin
               errors++;
               $display("FAIL readall_grant a=%0d: got %b, want 0001", a, req_ready);
            end
         end
         if (a > 0) begin
            exp_d = (a - 1 < lim) ? '0 : snap[a-1];
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== exp_d) begin
               errors++;
               $display("FAIL readall_data a=%0d: got %b/%h, want 0001/%h", a - 1, rsp_valid, rsp_data, exp_d);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_clear();
      int  busy_cnt = 0;
      bit  ended = 0;
      @(negedge clk);
      drive_idle();
      req_valid = 4'b0001; req_addr[0 +: AW] = 5'd7; clr_start = 1;
      #1; model_eval();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL clear_start_grant: got %b, want 0001", req_ready);
      end
      model_commit();
      for (int c = 0; c < 40 && !ended; c++) begin
         @(negedge clk);
         drive_idle();
         req_valid = '1; wr_valid = 1; wr_addr = AW'($urandom_range(0, D - 1)); clr_start = (c == 3);
         #1; model_eval();
         if (c == 0) begin
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== 32'hA5A5A5A5) begin
               errors++;
               $display("FAIL clear_old_rsp: got %b/%h, want 0001/a5a5a5a5", rsp_valid, rsp_data);
            end
         end
         if (clr_busy === 1'b1) begin
            checks++;
            if (wr_ready !== 0 || req_ready !== '0 || bram_ren !== 0 || bram_wren !== 1 ||
                bram_wraddr !== AW'(busy_cnt) || bram_wrdat !== '0) begin
               errors++;
               $display("FAIL clear_cycle c=%0d: got wr=%b rr=%b ren=%b wen=%b addr=%0d dat=%h, want 0/0/0/1/%0d/0",
                        c, wr_ready, req_ready, bram_ren, bram_wren, bram_wraddr, bram_wrdat, busy_cnt);
            end
            busy_cnt++;
         end else begin
            ended = 1;
            checks++;
            if (busy_cnt != D || clr_done !== 1'b1 || c != D) begin
               errors++;
               $display("FAIL clear_done: busy=%0d done=%b at c=%0d, want busy=32 done=1 at c=32",
                        busy_cnt, clr_done, c);
            end
         end
         model_commit();
      end
      if (!ended) begin
         errors++; checks++;
         $display("FAIL clear_timeout: clr_busy still %b after 40 cycles", clr_busy);
      end
      @(negedge clk);
      drive_idle();
      #1; model_eval();
      checks++;
      if (clr_done !== 1'b0) begin
         errors++;
         $display("FAIL clear_done_pulse: got %b one cycle later, want 0", clr_done);
      end
      model_commit();
      for (int a = 0; a < D; a++) snap[a] = '1;
      read_all(D);
   endtask

   task automatic test_clear_retrigger();
      int busy_cnt = 0, done_cnt = 0;
      for (int c = -1; c < 45; c++) begin
         @(negedge clk);
         drive_idle();
         clr_start = (c == -1 || c == 5 || c == 20);
         #1; model_eval();
         if (clr_busy === 1'b1) busy_cnt++;
         if (clr_done === 1'b1) done_cnt++;
         model_commit();
      end
      checks++;
      if (busy_cnt != D || done_cnt != 1) begin
         errors++;
         $display("FAIL clear_retrigger: busy=%0d done_pulses=%0d, want 32 and 1", busy_cnt, done_cnt);
      end
   endtask

   task automatic test_random();
      bit            pend [N];
      logic [AW-1:0] paddr [N];
      for (int i = 0; i < N; i++) pend[i] = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1; paddr[i] = AW'($urandom_range(0, 7));
            end
            req_valid[i] = pend[i];
            req_addr[i*AW +: AW] = pend[i] ? paddr[i] : AW'($urandom_range(0, D - 1));
         end
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_addr = AW'($urandom_range(0, 7));
         wr_data = $urandom;
         clr_start = ($urandom_range(0, 99) == 0);
         #1; model_eval();
         checks++;
         if (req_ready !== e_grant || bram_ren !== (e_grant != 0) || (e_grant != 0 && bram_raddr !== e_raddr) ||
             bram_wren !== e_wren || (e_wren && (bram_wraddr !== e_waddr || bram_wrdat !== e_wdata)) ||
             wr_ready !== !m_clr || clr_busy !== m_clr || clr_done !== m_done || rsp_valid !== m_prev ||
             (m_prev != 0 && rsp_data !== m_pdata)) begin
            errors++;
            $display("FAIL random n=%0d: got rr=%b ren=%b ra=%0d wen=%b wa=%0d wd=%h rv=%b rd=%h busy=%b done=%b; want rr=%b ra=%0d wen=%b wa=%0d wd=%h rv=%b rd=%h busy=%b done=%b",
                     n, req_ready, bram_ren, bram_raddr, bram_wren, bram_wraddr, bram_wrdat, rsp_valid, rsp_data,
                     clr_busy, clr_done, e_grant, e_raddr, e_wren, e_waddr, e_wdata, m_prev, m_pdata, m_clr, m_done);
         end
         for (int i = 0; i < N; i++) if (e_grant[i]) pend[i] = 0;
         model_commit();
      end
      for (int n = 0; n < 40 && (m_clr || m_done); n++) begin
         @(negedge clk);
         drive_idle();
         #1; model_eval();
         checks++;
         if (clr_busy !== m_clr) begin
            errors++;
            $display("FAIL random_drain n=%0d: clr_busy got %b want %b", n, clr_busy, m_clr);
         end
         model_commit();
      end
   endtask

   task automatic test_reset_mid_clear();
      int done_cnt = 0;
      test_write_passthru();
      for (int a = 0; a < D; a++) snap[a] = m_mem[a];
      @(negedge clk);
      drive_idle(); clr_start = 1;
      #1; model_eval(); model_commit();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive_idle();
         #1; model_eval(); model_commit();
      end
      @(negedge clk);
      drive_idle(); req_valid = '1; wr_valid = 1;
      #1;
      checks++;
      if (clr_busy !== 1'b1 || bram_wraddr !== 5'd10) begin
         errors++;
         $display("FAIL midclear_pre: busy=%b wraddr=%0d, want 1/10", clr_busy, bram_wraddr);
      end
      rst_n = 0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, wr_ready, bram_ren, bram_wren, clr_busy, clr_done} !== '0) begin
         errors++;
         $display("FAIL midclear_async_reset: rr=%b rv=%b wr=%b ren=%b wen=%b busy=%b done=%b, want all 0",
                  req_ready, rsp_valid, wr_ready, bram_ren, bram_wren, clr_busy, clr_done);
      end
      model_reset();
      @(negedge clk);
      drive_idle();
      rst_n = 1;
      #1; model_eval(); model_commit();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         drive_idle();
         #1; model_eval();
         if (clr_done === 1'b1 || clr_busy === 1'b1) done_cnt++;
         model_commit();
      end
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL midclear_no_done: %0d cycles with busy/done after reset, want 0", done_cnt);
      end
      read_all(10);
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 0;
      drive_idle();
      for (int a = 0; a < D; a++) m_mem[a] = '0;
      model_reset();
      test_reset();
      test_write_passthru();
      test_rr_all();
      test_ptr_wrap();
      test_collision();
      test_clear();
      test_clear_retrigger();
      test_random();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
